// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, enable constants, receiver FSM encoding.
// Optional feature macro: UART_RX_PARITY_EN (adds the PARITY state, 8E1 framing).
package uart_pkg;

  localparam int unsigned DATA_W = 8;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_e;

  // Even parity holds when data plus parity bit carry an even number of ones.
  function automatic logic parity_ok(input logic [DATA_W-1:0] data, input logic par);
    return (^{data, par}) == 1'b0;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO with wrap-bit pointers; a push while full is dropped
// and flagged unless a pop frees the head slot in the same cycle.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              rstd,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              ovf_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              do_push, do_pop;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    empty_o  = (wr_ptr_q == rd_ptr_q);
    full_o   = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
               (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full_o || do_pop);
    ovf_o    = push_i && full_o && !do_pop;
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    data_o   = empty_o ? '0 : mem_q[rd_ptr_q[IDX_W-1:0]];
  end

  always_ff @(posedge clk or negedge rstd) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rstd) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage has no reset; entries are only visible between valid pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[IDX_W-1:0]] <= data_i;
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling FSM and receive FIFO
// with sticky error flags. Define UART_RX_PARITY_EN for 8E1, otherwise 8N1.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100000000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rstd,
  input  logic              rx_i,
  input  logic              rd_en_i,
  input  logic              err_clr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rx_valid_o,
  output logic              rx_full_o,
  output logic              frm_err_o,
  output logic              ovf_err_o,
  output logic              par_err_o
);

  localparam int unsigned DIV   = CLK_FREQ / BAUD_RATE;
  localparam int unsigned HALF  = DIV / 2;
  localparam int unsigned CNT_W = $clog2(DIV + 1);

  // sync_q[1] is the synchronized line; sync_q[2] is its previous value for edge detect.
  logic [2:0]        sync_q, sync_d;
  logic              rx_s, fall;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              push_q, push_d;
  logic              frm_q, frm_d;
  logic              ovf_q, ovf_d;
  logic              tick, stop_smp, par_ok, frm_evt, par_evt, ovf_evt;
  logic              fifo_empty;
`ifdef UART_RX_PARITY_EN
  logic              par_q, par_d;
  logic              par_err_q, par_err_d;
`endif

  always_comb begin
    sync_d = {sync_q[1:0], rx_i};
    rx_s   = sync_q[1];
    fall   = sync_q[2] && !sync_q[1];
    tick   = (cnt_q == CNT_W'(DIV - 1));
  end

  // State register
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      sync_q    <= '1;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      data_q    <= '0;
      push_q    <= 1'b0;
      frm_q     <= 1'b0;
      ovf_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q     <= 1'b0;
      par_err_q <= 1'b0;
`endif
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      data_q    <= data_d;
      push_q    <= push_d;
      frm_q     <= frm_d;
      ovf_q     <= ovf_d;
`ifdef UART_RX_PARITY_EN
      par_q     <= par_d;
      par_err_q <= par_err_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    bit_d   = bit_q;
    data_d  = data_q;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (fall) state_d = ST_START;
      end
      ST_START: begin
        if (cnt_q == CNT_W'(HALF)) begin
          cnt_d   = '0;
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          cnt_d  = '0;
          data_d = {rx_s, data_q[DATA_W-1:1]};
          bit_d  = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          cnt_d   = '0;
          par_d   = rx_s;
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output logic: frame verdict at the stop-bit sample, pushed one clock later.
  always_comb begin
    stop_smp = (state_q == ST_STOP) && tick;
`ifdef UART_RX_PARITY_EN
    par_ok   = parity_ok(data_q, par_q);
`else
    par_ok   = ENABLE;
`endif
    push_d   = DISABLE;
    frm_evt  = DISABLE;
    par_evt  = DISABLE;
    if (stop_smp) begin
      push_d  = rx_s && par_ok;
      frm_evt = !rx_s;
      par_evt = !par_ok;
    end
  end

  // Sticky flags: a same-cycle error event beats the clear.
  always_comb begin
    frm_d     = (frm_q && !err_clr_i) || frm_evt;
    ovf_d     = (ovf_q && !err_clr_i) || ovf_evt;
`ifdef UART_RX_PARITY_EN
    par_err_d = (par_err_q && !err_clr_i) || par_evt;
`endif
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstd    (rstd),
    .push_i  (push_q),
    .data_i  (data_q),
    .pop_i   (rd_en_i),
    .data_o  (rd_data_o),
    .empty_o (fifo_empty),
    .full_o  (rx_full_o),
    .ovf_o   (ovf_evt)
  );

  assign rx_valid_o = !fifo_empty;
  assign frm_err_o  = frm_q;
  assign ovf_err_o  = ovf_q;
`ifdef UART_RX_PARITY_EN
  assign par_err_o  = par_err_q;
`else
  assign par_err_o  = 1'b0;
  logic unused_par;
  assign unused_par = par_evt;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus random bytes compared
// against a queue-based receiver model. Bit rate is scaled up to keep runs short.
module tb_uart_rx;

  localparam int unsigned CLK_FREQ = 100000000;
  localparam int unsigned BAUD     = 5000000;
  localparam int unsigned DIV      = CLK_FREQ / BAUD;   // 20 clocks per bit
  localparam int unsigned DEPTH    = 4;
  localparam int          CLK_P    = 10;
  localparam int          BIT_T    = DIV * CLK_P;

  logic       clk = 1'b0;
  logic       rstd = 1'b0;
  logic       rx_i = 1'b1;
  logic       rd_en_i = 1'b0;
  logic       err_clr_i = 1'b0;
  logic [7:0] rd_data_o;
  logic       rx_valid_o, rx_full_o, frm_err_o, ovf_err_o, par_err_o;

  uart_rx #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rstd       (rstd),
    .rx_i       (rx_i),
    .rd_en_i    (rd_en_i),
    .err_clr_i  (err_clr_i),
    .rd_data_o  (rd_data_o),
    .rx_valid_o (rx_valid_o),
    .rx_full_o  (rx_full_o),
    .frm_err_o  (frm_err_o),
    .ovf_err_o  (ovf_err_o),
    .par_err_o  (par_err_o)
  );

  always #(CLK_P / 2) clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int start_cyc = 0;
  int rise_cyc = -1;
  int lat = 9 * DIV + DIV / 2;
  logic valid_prev = 1'b0;

  // Receiver model: received bytes and sticky flags.
  logic [7:0] exp_q[$];
  logic       m_frm = 1'b0, m_ovf = 1'b0, m_par = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid_o && !valid_prev && rise_cyc < 0) rise_cyc = cyc;
    valid_prev = rx_valid_o;
  end

  initial begin
    #(CLK_P * 50000);
    $display("FAIL timeout: simulation did not finish within budget");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic even_par(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += b[i];
    return logic'(ones % 2);
  endfunction

  // Frame accepted by the receiver: full FIFO drops it and flags overflow.
  task automatic model_rx(input logic [7:0] b, input bit stop_ok, input bit par_good);
    if (!stop_ok) m_frm = 1'b1;
    if (!par_good) m_par = 1'b1;
    if (stop_ok && par_good) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
    @(posedge clk);
    #3;
    start_cyc = cyc;
    rx_i = 1'b0;
    #(BIT_T);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      #(BIT_T);
    end
`ifdef UART_RX_PARITY_EN
    rx_i = even_par(b) ^ par_flip;
    #(BIT_T);
`else
    if (par_flip) rx_i = 1'b1;
`endif
    rx_i = stop_bit;
    #(BIT_T);
    rx_i = 1'b1;
    #(BIT_T);
  endtask

  task automatic check_state(input string tag);
    @(negedge clk);
    check({tag, "_valid"}, rx_valid_o, exp_q.size() != 0);
    check({tag, "_full"},  rx_full_o,  exp_q.size() == DEPTH);
    check({tag, "_data"},  rd_data_o,  (exp_q.size() != 0) ? exp_q[0] : 8'h00);
    check({tag, "_frm"},   frm_err_o,  m_frm);
    check({tag, "_ovf"},   ovf_err_o,  m_ovf);
    check({tag, "_par"},   par_err_o,  m_par);
  endtask

  task automatic pop_check(input string tag);
    @(negedge clk);
    check(tag, rd_data_o, (exp_q.size() != 0) ? exp_q[0] : 8'h00);
    rd_en_i = 1'b1;
    @(negedge clk);
    rd_en_i = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
  endtask

  task automatic clear_errors();
    @(negedge clk);
    err_clr_i = 1'b1;
    @(negedge clk);
    err_clr_i = 1'b0;
    m_frm = 1'b0;
    m_ovf = 1'b0;
    m_par = 1'b0;
  endtask

  initial begin
    logic [7:0] b;

    // Reset values
    repeat (3) @(posedge clk);
    check_state("reset");
    #3 rstd = 1'b1;
    repeat (4) @(posedge clk);

    // 0xA5: latency, data, then pop to empty
    rise_cyc = -1;
    send_frame(8'hA5, 1'b1, 1'b0);
    model_rx(8'hA5, 1'b1, 1'b1);
    for (int i = 0; i < 2 * DIV && rise_cyc < 0; i++) @(posedge clk);
    check("a5_latency_in_window",
          (rise_cyc >= 0) && (rise_cyc - start_cyc >= 9 * DIV) && (rise_cyc - start_cyc <= 10 * DIV), 1);
    if (rise_cyc >= 0) lat = rise_cyc - start_cyc;
    check_state("a5");
    pop_check("a5_pop");
    check_state("a5_empty");

    // Short low glitch: no byte, no flags, and the next frame is still received
    @(posedge clk);
    #3 rx_i = 1'b0;
    #(5 * CLK_P) rx_i = 1'b1;
    #(2 * BIT_T);
    check_state("glitch");
    b = 8'($urandom_range(0, 255));
    send_frame(b, 1'b1, 1'b0);
    model_rx(b, 1'b1, 1'b1);
    check_state("post_glitch");
    pop_check("post_glitch_pop");

    // 0x3C with stop bit low: framing error, nothing stored
    send_frame(8'h3C, 1'b0, 1'b0);
    model_rx(8'h3C, 1'b0, 1'b1);
    check_state("frame_err");
    clear_errors();
    check_state("frame_err_clr");

    // Five bytes into a four-entry FIFO
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1, 1'b0);
      model_rx(8'(i), 1'b1, 1'b1);
      check_state($sformatf("fill_%0d", i));
    end
    for (int i = 0; i < 5; i++) pop_check($sformatf("drain_%0d", i));
    check_state("drained");
    clear_errors();
    check_state("ovf_clr");

    // Full FIFO with a pop on the same clock as the 5th push
    for (int i = 1; i <= 4; i++) begin
      send_frame(8'(i), 1'b1, 1'b0);
      model_rx(8'(i), 1'b1, 1'b1);
    end
    check_state("refill");
    fork
      send_frame(8'h05, 1'b1, 1'b0);
      begin
        @(posedge clk);
        #3;
        repeat (lat) @(negedge clk);
        rd_en_i = 1'b1;
        @(negedge clk);
        rd_en_i = 1'b0;
      end
    join
    void'(exp_q.pop_front());
    exp_q.push_back(8'h05);
    check_state("push_pop_full");
    for (int i = 0; i < 4; i++) pop_check($sformatf("pp_drain_%0d", i));
    check_state("pp_empty");

    // Random bytes with random idle gaps
    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(0, 2 * DIV)) @(posedge clk);
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b1, 1'b0);
      model_rx(b, 1'b1, 1'b1);
    end
    check_state("rand");
    for (int i = 0; i < 3; i++) pop_check($sformatf("rand_pop_%0d", i));

    // Reset in the middle of 0x55 data bits, with a byte already queued
    send_frame(8'h9E, 1'b1, 1'b0);
    model_rx(8'h9E, 1'b1, 1'b1);
    b = 8'h55;
    @(posedge clk);
    #3 rx_i = 1'b0;
    #(BIT_T);
    for (int i = 0; i < 4; i++) begin
      rx_i = b[i];
      #(BIT_T);
    end
    rx_i = b[4];
    #(BIT_T / 2);
    rstd = 1'b0;
    #1;
    check("rst_async_valid", rx_valid_o, 1'b0);
    check("rst_async_data", rd_data_o, 8'h00);
    rx_i = 1'b1;
    exp_q.delete();
    m_frm = 1'b0;
    m_ovf = 1'b0;
    m_par = 1'b0;
    repeat (3) @(posedge clk);
    #3 rstd = 1'b1;
    #(2 * BIT_T);
    check_state("after_reset");
    send_frame(8'h81, 1'b1, 1'b0);
    model_rx(8'h81, 1'b1, 1'b1);
    check_state("rx_81");
    pop_check("rx_81_pop");
    check_state("rx_81_empty");

`ifdef UART_RX_PARITY_EN
    // 0x81 with the wrong parity bit: parity error, nothing stored
    send_frame(8'h81, 1'b1, 1'b1);
    model_rx(8'h81, 1'b1, 1'b0);
    check_state("par_err");
    clear_errors();
    check_state("par_err_clr");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
